mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
//   Front-end of the MEM stage. Sits between the EXE/MEM pipeline register and the 64-word data memory array.
//   Translates byte addresses to word indices and sequences multi-cycle (wait-stated) reads and writes.
//   Freezes the pipeline while an access is in flight; returns read data to MEM/WB.
// PARAMETERS
//   BASE_ADDR    1024  byte address of memory word 0
//   DEPTH        64    number of 32-bit words in the array
//   ADDR_W       6     array index width, = clog2(DEPTH)
//   WAIT_CYCLES  1     extra array cycles per access (0..15)
// PORTS
//   clk        in   1       rising-edge clock
//   rst        in   1       asynchronous reset, active-low (0 = reset)
//   MEM_R_EN   in   1       load request from EXE/MEM register
//   MEM_W_EN   in   1       store request from EXE/MEM register
//   alu_res    in   32      byte address
//   rm_val     in   32      store data
//   ram_rdata  in   32      array read data, valid while ram_re=1
//   ram_addr   out  ADDR_W  array word index
//   ram_wdata  out  32      array write data
//   ram_re     out  1       array read strobe
//   ram_we     out  1       array write strobe, one cycle per store
//   freeze     out  1       stall IF..EXE/MEM registers
//   rd_data    out  32      load result to MEM/WB
//   ready      out  1       1-cycle pulse: access complete, rd_data valid
//   addr_err   out  1       1-cycle pulse with ready: access rejected
// BEHAVIOUR
//   Reset (rst=0, async): state=IDLE.
//     All outputs 0, including freeze. Latched address, data and op are cleared.
//     An in-flight store is aborted: ram_we drops immediately and the array is not written.
//   FSM states:
//     IDLE
//       - On req = MEM_R_EN|MEM_W_EN: latch index, rm_val, op.
//       - Next state = ERR if the address is bad, else ACCESS with cnt=WAIT_CYCLES.
//       - freeze=req, driven combinationally.
//     ACCESS
//       - freeze=1. ram_addr and ram_wdata come from the latches.
//       - Load: ram_re=1 in every ACCESS cycle.
//       - Store: ram_we=1 only when cnt==0.
//       - cnt!=0: cnt-- and stay in ACCESS.
//       - cnt==0: capture ram_rdata into rd_data (load only), next state = DONE.
//     ERR
//       - freeze=1 for one cycle. No strobes. rd_data=0. Next state = DONE with err flag set.
//     DONE
//       - freeze=0, ready=1, addr_err=err flag. Next state = IDLE.
//       - The pipeline advances on this edge.
//       - Request inputs are ignored in DONE; they still hold the completed instruction.
//   Latency
//     - Good access: WAIT_CYCLES+2 frozen cycles, then the DONE cycle.
//     - Bad address: 2 frozen cycles (IDLE, ERR), then DONE.
//   Address rules
//     - off = alu_res - BASE_ADDR, computed 32-bit unsigned. index = off[ADDR_W+1:2].
//     - Bad address if any of: alu_res < BASE_ADDR; off >= 4*DEPTH; alu_res[1:0] != 0.
//     - A bad store never strobes ram_we. A bad load returns 0.
//   Simultaneous MEM_R_EN and MEM_W_EN: treated as a store, not an error.
//   rd_data
//     - Holds its value until the next load completes.
//     - Stores and errors do not update it, except that an errored load sets it to 0.
//   Back-to-back requests: each request is accepted from IDLE. There is no request bubble beyond DONE.
//   Outputs other than freeze are registered or decoded from state and latches only.
//     freeze in IDLE is the sole input-to-output combinational path.
// STRUCTURE
//   Package mem_pkg:
//     - enum logic [1:0] mem_state_t {IDLE, ACCESS, ERR, DONE}
//     - MEM_BASE_ADDR=1024, MEM_DEPTH=64
//     - function mem_addr_ok(addr) returning the bad-address check
//   Sub-module wait_counter: load, decrement, zero flag; 4 bits.
//     Instantiated once and loaded on the IDLE->ACCESS transition.
//   The array itself is external and is not part of this block.
// TESTING
//   - Reset: hold rst=0 with MEM_W_EN=1 -> freeze=0, ram_we=0, ready=0, rd_data=0.
//   - Store then load, WAIT_CYCLES=1.
//       - Store: W alu_res=1032 rm_val=0xDEADBEEF -> freeze high 3 cycles; ram_we exactly 1 cycle with ram_addr=2; ready in cycle 4.
//       - Load: R alu_res=1032 -> rd_data=0xDEADBEEF with ready.
//   - Boundaries:
//       - R alu_res=1020 -> addr_err=1, rd_data=0, no ram_re.
//       - R alu_res=1024+252 -> index 63, ok.
//       - R alu_res=1280 -> addr_err=1.
//       - R alu_res=1026 (misaligned) -> addr_err=1.
//   - Both enables with alu_res=1024 rm_val=5 -> one ram_we with ram_wdata=5; rd_data unchanged.
//   - Reset mid-store: drop rst during ACCESS with cnt=1 -> ram_we never asserts, state IDLE, freeze=0 at once.
//   - WAIT_CYCLES=0 back-to-back loads of 1024, 1028 -> 2 frozen cycles each; two ready pulses 3 cycles apart.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and address checking for the MEM-stage access controller.
// The address check is shared so any block decoding data addresses agrees on "bad".
package mem_pkg;

   typedef enum logic [1:0] {IDLE, ACCESS, ERR, DONE} mem_state_t;

   localparam int unsigned MEM_BASE_ADDR = 1024;
   localparam int unsigned MEM_DEPTH     = 64;

   // 1 when addr is word-aligned and falls inside [base, base + 4*depth).
   function automatic logic mem_addr_ok(input logic [31:0] addr,
                                        input logic [31:0] base  = MEM_BASE_ADDR,
                                        input logic [31:0] depth = MEM_DEPTH);
      logic [31:0] off;
      off = addr - base;
      return (addr >= base) && (off < (depth << 2)) && (addr[1:0] == 2'b00);
   endfunction

endpackage

// File: rtl/wait_counter.sv
// 4-bit wait-state counter: parallel load, decrement that saturates at zero,
// and a zero flag used to end an array access.
module wait_counter (
   input  logic       clk,
   input  logic       rst,
   input  logic       load_i,
   input  logic [3:0] load_val_i,
   input  logic       dec_i,
   output logic       zero_o
);

   logic [3:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i)
         cnt_d = load_val_i;
      else if (dec_i && cnt_q != 4'd0)
         cnt_d = cnt_q - 4'd1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
   end

   assign zero_o = (cnt_q == 4'd0);

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage front-end: byte address to word index translation, wait-stated
// access sequencing to an external array, and pipeline freeze while busy.
module mem_access_ctrl
   import mem_pkg::*;
#(
   parameter int unsigned BASE_ADDR   = MEM_BASE_ADDR,
   parameter int unsigned DEPTH       = MEM_DEPTH,
   parameter int unsigned ADDR_W      = $clog2(DEPTH),
   parameter int unsigned WAIT_CYCLES = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              MEM_R_EN,
   input  logic              MEM_W_EN,
   input  logic [31:0]       alu_res,
   input  logic [31:0]       rm_val,
   input  logic [31:0]       ram_rdata,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [31:0]       ram_wdata,
   output logic              ram_re,
   output logic              ram_we,
   output logic              freeze,
   output logic [31:0]       rd_data,
   output logic              ready,
   output logic              addr_err
);

   mem_state_t        state_q;
   logic [ADDR_W-1:0] idx_q;
   logic [31:0]       wdata_q, rd_data_q;
   logic              st_q, ld_q, err_q;

   logic              req, addr_ok, cnt_zero;
   logic [ADDR_W-1:0] idx_d;

   assign req     = MEM_R_EN | MEM_W_EN;
   assign addr_ok = mem_addr_ok(alu_res, BASE_ADDR, DEPTH);
   assign idx_d   = ADDR_W'((alu_res - BASE_ADDR) >> 2);

   wait_counter u_wait (
      .clk        (clk),
      .rst        (rst),
      .load_i     ((state_q == IDLE) && req && addr_ok),
      .load_val_i (4'(WAIT_CYCLES)),
      .dec_i      (state_q == ACCESS),
      .zero_o     (cnt_zero)
   );

   // Both enables together are a store; only a pure load touches rd_data.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         wdata_q   <= '0;
         st_q      <= 1'b0;
         ld_q      <= 1'b0;
         err_q     <= 1'b0;
         rd_data_q <= '0;
      end else begin
         case (state_q)
            IDLE: if (req) begin
               idx_q   <= idx_d;
               wdata_q <= rm_val;
               st_q    <= MEM_W_EN;
               ld_q    <= MEM_R_EN & ~MEM_W_EN;
               err_q   <= ~addr_ok;
               state_q <= addr_ok ? ACCESS : ERR;
            end
            ACCESS: if (cnt_zero) begin
               if (ld_q) rd_data_q <= ram_rdata;
               state_q <= DONE;
            end
            ERR: begin
               if (ld_q) rd_data_q <= '0;
               state_q <= DONE;
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign ram_addr  = idx_q;
   assign ram_wdata = wdata_q;
   assign ram_re    = (state_q == ACCESS) & ld_q;
   assign ram_we    = (state_q == ACCESS) & st_q & cnt_zero;
   // Reset gating keeps freeze low while rst is held even with a request present.
   assign freeze    = rst & ((state_q == IDLE) ? req
                                               : (state_q == ACCESS || state_q == ERR));
   assign rd_data   = rd_data_q;
   assign ready     = (state_q == DONE);
   assign addr_err  = (state_q == DONE) & err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: one instance with one wait state, one with none,
// each backed by its own array and checked against a word-level memory model.
module tb_mem_access_ctrl;

   localparam int BASE  = 1024;
   localparam int DEPTH = 64;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        r_en [2];
   logic        w_en [2];
   logic [31:0] addr [2];
   logic [31:0] wd   [2];
   logic [31:0] rdata[2];
   logic [5:0]  raddr[2];
   logic [31:0] wdo  [2];
   logic        re   [2];
   logic        we   [2];
   logic        fz   [2];
   logic [31:0] rdo  [2];
   logic        rdy  [2];
   logic        aerr [2];

   bit   [31:0] mem     [2][64];
   bit   [31:0] ref_mem [2][64];
   logic [31:0] exp_rd  [2];
   int          last_ready [2];
   int          ntests = 0;
   int          nfail  = 0;
   int          tick   = 0;

   mem_access_ctrl #(.WAIT_CYCLES(1)) dut0 (
      .clk(clk), .rst(rst), .MEM_R_EN(r_en[0]), .MEM_W_EN(w_en[0]),
      .alu_res(addr[0]), .rm_val(wd[0]), .ram_rdata(rdata[0]),
      .ram_addr(raddr[0]), .ram_wdata(wdo[0]), .ram_re(re[0]), .ram_we(we[0]),
      .freeze(fz[0]), .rd_data(rdo[0]), .ready(rdy[0]), .addr_err(aerr[0]));

   mem_access_ctrl #(.WAIT_CYCLES(0)) dut1 (
      .clk(clk), .rst(rst), .MEM_R_EN(r_en[1]), .MEM_W_EN(w_en[1]),
      .alu_res(addr[1]), .rm_val(wd[1]), .ram_rdata(rdata[1]),
      .ram_addr(raddr[1]), .ram_wdata(wdo[1]), .ram_re(re[1]), .ram_we(we[1]),
      .freeze(fz[1]), .rd_data(rdo[1]), .ready(rdy[1]), .addr_err(aerr[1]));

   assign rdata[0] = mem[0][raddr[0]];
   assign rdata[1] = mem[1][raddr[1]];

   always @(posedge clk) begin
      tick <= tick + 1;
      for (int i = 0; i < 2; i++)
         if (we[i]) mem[i][raddr[i]] <= wdo[i];
   end

   function automatic int wc(input int d);
      return (d == 0) ? 1 : 0;
   endfunction

   function automatic bit model_ok(input logic [31:0] a);
      return (a >= BASE) && (a < BASE + 4 * DEPTH) && (a % 4 == 0);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Issue one request on instance d and hold it until ready, then compare
   // the whole transaction against the memory model.
   task automatic access(input int d, input bit r, input bit w,
                         input logic [31:0] a, input logic [31:0] v);
      bit   ok, is_ld, is_st, got;
      int   idx, lat, cyc, nfz, nwe, nre, we_cyc, fz_at_rdy;
      logic [31:0] we_a, we_d, got_rd;
      logic got_err;
      ok    = model_ok(a);
      idx   = ok ? (a - BASE) / 4 : 0;
      is_st = w;
      is_ld = r && !w;
      lat   = ok ? wc(d) + 2 : 2;
      if (is_st && ok) ref_mem[d][idx] = v;
      if (is_ld) exp_rd[d] = ok ? ref_mem[d][idx] : 32'h0;

      @(negedge clk);
      r_en[d] = r; w_en[d] = w; addr[d] = a; wd[d] = v;
      cyc = 0; nfz = 0; nwe = 0; nre = 0; got = 0; we_cyc = 0;
      we_a = '0; we_d = '0; got_rd = '0; got_err = 1'b0; fz_at_rdy = 0;
      while (!got && cyc < 40) begin
         #1;
         cyc++;
         if (rdy[d]) begin
            got       = 1;
            got_rd    = rdo[d];
            got_err   = aerr[d];
            fz_at_rdy = fz[d];
            last_ready[d] = tick;
         end else begin
            if (fz[d]) nfz++;
            if (re[d]) nre++;
            if (we[d]) begin
               nwe++; we_cyc = cyc; we_a = 32'(raddr[d]); we_d = wdo[d];
            end
            @(negedge clk);
         end
      end
      check($sformatf("d%0d @%0d ready_seen", d, a), 32'(got), 32'd1);
      check($sformatf("d%0d @%0d ready_cycle", d, a), cyc, lat + 1);
      check($sformatf("d%0d @%0d freeze_cycles", d, a), nfz, lat);
      check($sformatf("d%0d @%0d freeze_at_ready", d, a), fz_at_rdy, 0);
      check($sformatf("d%0d @%0d we_count", d, a), nwe, (is_st && ok) ? 1 : 0);
      check($sformatf("d%0d @%0d re_count", d, a), nre, (is_ld && ok) ? wc(d) + 1 : 0);
      if (nwe == 1) begin
         check($sformatf("d%0d @%0d we_index", d, a), we_a, idx);
         check($sformatf("d%0d @%0d we_data", d, a), we_d, v);
         check($sformatf("d%0d @%0d we_cycle", d, a), we_cyc, lat);
      end
      check($sformatf("d%0d @%0d addr_err", d, a), 32'(got_err), 32'(!ok));
      check($sformatf("d%0d @%0d rd_data", d, a), got_rd, exp_rd[d]);
   endtask

   task automatic idle(input int d);
      @(negedge clk);
      r_en[d] = 1'b0; w_en[d] = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0, k, op;
      logic [31:0] a;
      rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         r_en[i] = 1'b0; w_en[i] = 1'b1; addr[i] = 32'd1032; wd[i] = 32'h1; exp_rd[i] = '0;
         last_ready[i] = 0;
      end

      // Reset held with a store request present.
      repeat (2) @(negedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         check($sformatf("d%0d reset freeze", i), 32'(fz[i]), 0);
         check($sformatf("d%0d reset ram_we", i), 32'(we[i]), 0);
         check($sformatf("d%0d reset ready", i), 32'(rdy[i]), 0);
         check($sformatf("d%0d reset rd_data", i), rdo[i], 0);
      end
      w_en[0] = 1'b0; w_en[1] = 1'b0;
      @(negedge clk);
      rst = 1'b1;

      // Store then load with one wait state, then the boundaries.
      access(0, 0, 1, 1032, 32'hDEADBEEF); idle(0);
      access(0, 1, 0, 1032, 0);            idle(0);
      access(0, 1, 0, 1020, 0);            idle(0);
      access(0, 0, 1, 1024 + 252, 32'hCAFE0063); idle(0);
      access(0, 1, 0, 1024 + 252, 0);      idle(0);
      access(0, 1, 0, 1032, 0);            idle(0);
      access(0, 1, 0, 1280, 0);            idle(0);
      access(0, 1, 0, 1032, 0);            idle(0);
      access(0, 1, 0, 1026, 0);            idle(0);
      access(0, 1, 0, 1032, 0);            idle(0);
      access(0, 1, 1, 1024, 32'd5);        idle(0);
      access(0, 0, 1, 1020, 32'h77);       idle(0);
      access(0, 1, 0, 1024, 0);            idle(0);

      // Reset while a store sits in its first wait state.
      @(negedge clk);
      w_en[0] = 1'b1; addr[0] = 32'd1100; wd[0] = 32'h12345678;
      @(negedge clk); #1;
      check("midreset access freeze", 32'(fz[0]), 1);
      check("midreset access we", 32'(we[0]), 0);
      rst = 1'b0;
      #1;
      check("midreset freeze", 32'(fz[0]), 0);
      check("midreset we", 32'(we[0]), 0);
      check("midreset ready", 32'(rdy[0]), 0);
      w_en[0] = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk); #1;
         check("midreset hold we", 32'(we[0]), 0);
      end
      check("midreset array untouched", mem[0][19], ref_mem[0][19]);
      @(negedge clk);
      rst = 1'b1;
      exp_rd[0] = '0; exp_rd[1] = '0;
      access(0, 1, 0, 1100, 0);            idle(0);

      // Zero wait states: back-to-back loads.
      access(1, 0, 1, 1024, 32'hA5A50001); idle(1);
      access(1, 0, 1, 1028, 32'h5A5A0002); idle(1);
      access(1, 1, 0, 1024, 0);
      t0 = last_ready[1];
      access(1, 1, 0, 1028, 0);
      check("b2b ready spacing", last_ready[1] - t0, 3);
      idle(1);

      // Randomized mix of loads/stores over good and bad addresses.
      for (int n = 0; n < 80; n++) begin
         int d;
         d  = $urandom_range(0, 1);
         op = $urandom_range(1, 3);
         k  = $urandom_range(0, 5);
         case (k)
            0, 1, 2: a = BASE + 4 * $urandom_range(0, DEPTH - 1);
            3:       a = BASE + 4 * $urandom_range(0, DEPTH - 1) + $urandom_range(1, 3);
            4:       a = $urandom_range(0, BASE - 1);
            default: a = BASE + 4 * DEPTH + $urandom_range(0, 1000);
         endcase
         access(d, op[0], op[1], a, $urandom);
         idle(d);
      end

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
